// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: one write per rx_end rising edge, FWFT read visible right after the write edge.
// When full, rx_en_out drops to hold off new frames; a byte that still arrives is dropped and latched as a sticky overrun.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_end,
  output logic              rx_en_out,
  input  logic              en,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              overrun_clr,
  input  logic              int_en,
  output logic              int_req
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rx_end_d;
  logic              overrun_q;
  logic              wr_req;
  logic              rd_ok;
  logic              wr_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign count     = count_q;
  assign overrun   = overrun_q;
  assign wr_req    = rx_end & ~rx_end_d;
  assign rd_ok     = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok     = wr_req & (~full | rd_ok);
  assign rd_data   = empty ? 8'h00 : mem[rd_ptr];
  assign rx_en_out = en & ~full;
  assign int_req   = int_en & (~empty | overrun_q);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rx_end_d  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_end_d <= rx_end;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      // Setting wins over a same-cycle clear so no drop goes unreported.
      if (wr_req & full & ~rd_ok) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_end;
  logic              rx_en_out;
  logic              en;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              overrun_clr;
  logic              int_en;
  logic              int_req;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_end(rx_end),
    .rx_en_out(rx_en_out), .en(en), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .overrun(overrun),
    .overrun_clr(overrun_clr), .int_en(int_en), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue, a sticky flag and the previous rx_end level.
  logic [7:0] mq[$];
  logic       m_ovr;
  logic       m_prev;

  always @(negedge rst_n) begin
    mq.delete();
    m_ovr  = 1'b0;
    m_prev = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit edge_seen = rx_end && !m_prev;
      automatic bit pop       = rd_en && (mq.size() > 0);
      automatic bit was_full  = (mq.size() == DEPTH);
      automatic bit drop      = edge_seen && was_full && !pop;
      if (pop) void'(mq.pop_front());
      if (edge_seen && !drop) mq.push_back(rx_data);
      if (drop) m_ovr = 1'b1;
      else if (overrun_clr) m_ovr = 1'b0;
      m_prev = rx_end;
    end
  end

  always @(negedge clk) begin
    automatic int n = mq.size();
    chk("empty",     empty,     n == 0);
    chk("full",      full,      n == DEPTH);
    chk("count",     count,     n);
    chk("rd_data",   rd_data,   n > 0 ? mq[0] : 8'h00);
    chk("overrun",   overrun,   m_ovr);
    chk("int_req",   int_req,   int_en && (n != 0 || m_ovr));
    chk("rx_en_out", rx_en_out, en && n != DEPTH);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    rx_data = b;
    rx_end  = 1'b1;
    repeat (hold) cyc();
    rx_end  = 1'b0;
    cyc();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic fill_drain(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) send(base + 8'(i), 1);
    chk("fill_full", full, 1);
    chk("fill_cnt", count, DEPTH);
    chk("fill_rxen", rx_en_out, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("order", rd_data, base + 8'(i));
      pop();
    end
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_end = 1'b0; en = 1'b0; rd_en = 1'b0;
    overrun_clr = 1'b0; int_en = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1; en = 1'b1; int_en = 1'b1;
    cyc();
    chk("rst_empty", empty, 1);
    chk("rst_cnt", count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_int", int_req, 0);
    chk("rst_rxen", rx_en_out, 1);

    send(8'hA5, 3);
    chk("single_cnt", count, 1);
    chk("single_data", rd_data, 8'hA5);
    chk("single_int", int_req, 1);
    pop();
    chk("single_empty", empty, 1);
    chk("single_cnt0", count, 0);

    fill_drain(8'h00);
    for (int i = 0; i < 5; i++) begin send(8'hE0 + 8'(i), 1); pop(); end
    fill_drain(8'h00);

    // Overrun and set-beats-clear.
    for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i), 1);
    send(8'h77, 1);
    chk("ovr_set", overrun, 1);
    chk("ovr_cnt", count, DEPTH);
    rx_data = 8'h78; rx_end = 1'b1; overrun_clr = 1'b1;
    cyc();
    rx_end = 1'b0; overrun_clr = 1'b0;
    chk("ovr_setwins", overrun, 1);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Full with simultaneous write and pop.
    rx_data = 8'h3C; rx_end = 1'b1; rd_en = 1'b1;
    cyc();
    rx_end = 1'b0; rd_en = 1'b0;
    chk("fullrw_cnt", count, DEPTH);
    chk("fullrw_ovr", overrun, 0);
    chk("fullrw_head", rd_data, 8'h21);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    chk("fullrw_tail", rd_data, 8'h3C);
    pop();

    // Empty with simultaneous write and pop request.
    rx_data = 8'h11; rx_end = 1'b1; rd_en = 1'b1;
    cyc();
    rx_end = 1'b0; rd_en = 1'b0;
    chk("emptyrw_cnt", count, 1);
    chk("emptyrw_data", rd_data, 8'h11);
    pop();

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_cnt", count, 0);
    cyc();
    rst_n = 1'b1;
    send(8'h99, 1);
    chk("arst_next", rd_data, 8'h99);
    chk("arst_cnt1", count, 1);
    pop();

    // Randomized traffic with phases biased toward filling and draining.
    for (int c = 0; c < 3000; c++) begin
      automatic int phase = (c / 250) % 3;
      rx_data     = 8'($urandom);
      rx_end      = ($urandom_range(0, 2) == 0);
      rd_en       = (phase == 0) ? ($urandom_range(0, 7) == 0)
                  : (phase == 1) ? ($urandom_range(0, 1) == 0)
                  :                ($urandom_range(0, 3) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 63) == 0) int_en = ~int_en;
      cyc();
    end
    rx_end = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer sitting directly downstream of the UART receiver. Captures each completed byte on the receiver's end-of-frame pulse.
- Stores bytes in a DEPTH-entry circular FIFO and presents them to the CPU bus side with first-word-fall-through read semantics.
- Reports fill level, sticky overrun and an interrupt request. Gates the receiver's enable so no new frame is started when the buffer is full.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two and at least 2.
- ADDR_W, 4, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  byte from the receiver; valid while rx_end is high.
- rx_end  input  1  end-of-frame flag from the receiver; may be held high for more than one cycle.
- rx_en_out  output  1  enable to the receiver; equals en & ~full.
- en  input  1  software receive enable.
- rd_en  input  1  pop request; consumes the head entry.
- rd_data  output  8  head entry (FWFT); 8'h00 when empty.
- empty  output  1  high when count == 0.
- full  output  1  high when count == DEPTH.
- count  output  ADDR_W+1  number of stored entries.
- overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.
- int_en  input  1  interrupt enable.
- int_req  output  1  equals int_en & (~empty | overrun).

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overrun=0, rx_end_d=0.
  - Outputs during and after reset: empty=1, full=0, rd_data=8'h00, int_req=0, rx_en_out=en.
  - Memory contents are not reset.
- Capture event: wr_req = rx_end & ~rx_end_d, where rx_end_d is rx_end registered.
  - Exactly one write occurs per rising edge of rx_end, however long rx_end stays high.
  - rx_data is sampled in the same cycle wr_req is high.
- Write accepted when wr_req & (~full | rd_ok):
  - mem[wr_ptr] <= rx_data; wr_ptr <= wr_ptr+1.
  - The pointer wraps modulo DEPTH naturally through ADDR_W bits.
- Read: rd_ok = rd_en & ~empty; on rd_ok, rd_ptr <= rd_ptr+1 (wrapping). rd_en while empty is ignored with no state change.
- rd_data = mem[rd_ptr] combinationally when ~empty, so it is valid in the same cycle empty falls.
  - A byte written at edge N is visible on rd_data after edge N (zero-cycle fall-through beyond the write edge).
- Count update: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Simultaneous events:
  - Full with wr_req and rd_ok in the same cycle: both performed, no overrun, count stays DEPTH.
  - Empty with wr_req and rd_en in the same cycle: write performed, read ignored, count becomes 1.
- Overrun: wr_req & full & ~rd_ok drops the byte (no pointer or memory change) and sets overrun <= 1.
  - overrun_clr clears overrun.
  - If a set and a clear occur in the same cycle, the set wins.
- rx_en_out = en & ~full, combinational.
  - Deasserting it keeps the receiver idle; a frame already in progress still completes and may overrun.
- en low does not flush the FIFO. Stored data stays readable.
- Reset asserted mid-operation: state returns to reset values at once, and pending data is discarded.

Test Plan:
- Reset then idle: after reset, empty=1, count=0, rd_data=00, int_req=0. With en=1, rx_en_out=1.
- Single byte with rx_end held high for 3 cycles, rx_data=8'hA5: exactly one write. count=1, rd_data=A5, int_req=1 (int_en=1). Pulse rd_en once -> empty=1, count=0.
- Fill and order: write 16 bytes 00..0F -> full=1, count=16, rx_en_out=0. Read 16 times -> data out 00..0F in order, then empty=1. Repeat with pointers offset by 5 to exercise wrap-around.
- Overrun: with the FIFO full, send byte 8'h77 -> overrun=1, count=16, and 77 is never read out. Assert overrun_clr together with a new drop event -> overrun remains 1. Next cycle, overrun_clr alone -> overrun=0.
- Simultaneous events:
  - Full, with rx_end rising (8'h3C) and rd_en in the same cycle -> head popped, 3C stored at tail, count=16, overrun=0.
  - Empty, with rx_end rising (8'h11) and rd_en -> count=1, rd_data=11.
- Async reset mid-stream: with 5 entries stored, pull rst_n low between clock edges -> empty=1 and count=0 immediately without a clock edge. After release, the next byte is read first.
